memory_port_arbiter: RTL

MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

---
 rtl/memory_port_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/memory_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and MEM-stage load/store.
// Optional macro ARB_PERF_CNT_EN adds saturating stall-cycle counters.
module memory_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [CNT_W-1:0]  if_stall_cnt,
  output logic [CNT_W-1:0]  mem_stall_cnt,
  output logic [1:0]        fsm_state
);

  // Handshake: a request is held by the pipeline until its done pulse; the
  // memory holds off with ram_ready low and completes in the cycle it is high.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   fetch_first;
  logic   if_pend;
  logic   grant_data;
  logic   grant_fetch;
  logic   complete;

  // A request whose done pulse is showing this cycle is already served;
  // the pipeline only advances past it at the coming edge.
  assign stall_mem = (mem_read | mem_write) & ~mem_done;
  assign if_pend   = if_req & ~if_done;
  assign stall_if  = if_pend | stall_mem;
  assign fsm_state = state;

  always_comb begin
    next_state  = state;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    complete    = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_first && if_pend) begin
          grant_fetch = 1'b1;
          next_state  = FETCH;
        end else if (stall_mem) begin
          grant_data = 1'b1;
          next_state = DATA;
        end else if (if_pend) begin
          grant_fetch = 1'b1;
          next_state  = FETCH;
        end
      end
      DATA, FETCH: begin
        if (ram_ready) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ram_re      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      if_done     <= 1'b0;
      mem_done    <= 1'b0;
      fetch_first <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      if (grant_data) begin
        // Read and write together resolve to a write.
        ram_addr  <= mem_addr;
        ram_wdata <= mem_wdata;
        ram_we    <= mem_write;
        ram_re    <= ~mem_write;
      end else if (grant_fetch) begin
        ram_addr <= if_addr;
        ram_re   <= 1'b1;
        ram_we   <= 1'b0;
      end else if (complete) begin
        ram_re <= 1'b0;
        ram_we <= 1'b0;
        if (state == DATA) begin
          mem_done <= 1'b1;
          if (ram_re) mem_rdata <= ram_rdata;
        end else begin
          if_done  <= 1'b1;
          if_rdata <= ram_rdata;
        end
      end
      // Fetch gets the next grant after a data access that kept it waiting.
      if (complete && state == DATA) fetch_first <= if_req;
      else if (grant_fetch)          fetch_first <= 1'b0;
      else if (state == IDLE && !if_req) fetch_first <= 1'b0;
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
    end else begin
      if (stall_if && !(&if_stall_cnt))   if_stall_cnt  <= if_stall_cnt + CNT_W'(1);
      if (stall_mem && !(&mem_stall_cnt)) mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
    end
  end
`else
  assign if_stall_cnt  = '0;
  assign mem_stall_cnt = '0;
`endif

endmodule
